// File: rtl/console_writer_if.sv
// rtl/console_writer_if.sv - byte stream and character-buffer write port of the text console
interface console_writer_if;
    logic       char_valid;
    logic [7:0] char_data;
    logic       char_ready;
    logic       write_en;
    logic [4:0] write_row;
    logic [6:0] write_col;
    logic [7:0] write_char;

    modport master (
        output char_valid, char_data,
        input  char_ready, write_en, write_row, write_col, write_char
    );

    modport slave (
        input  char_valid, char_data,
        output char_ready, write_en, write_row, write_col, write_char
    );
endinterface

// File: rtl/console_writer.sv
// rtl/console_writer.sv - text console: cursor, control codes, screen/line clears, scroll via top_row
module console_writer #(
    parameter int         ROWS  = 30,
    parameter int         COLS  = 80,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    console_writer_if.slave      bus,
    input  logic                 clear,
    output logic                 busy,
    output logic [4:0]           cursor_row,
    output logic [6:0]           cursor_col,
    output logic [4:0]           top_row
);
    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LINE_CLR} state_t;

    state_t     state;
    logic [4:0] fill_row;
    logic [6:0] fill_col;
    logic [5:0] row_sum;
    logic [4:0] prow;
    logic       at_last_row;
    logic [4:0] adv_row;
    logic [4:0] adv_top;

    // top_row + cursor_row stays below 2*ROWS, so one subtract replaces the modulo
    assign row_sum = {1'b0, top_row} + {1'b0, cursor_row};
    assign prow    = (row_sum >= 6'(ROWS)) ? 5'(row_sum - 6'(ROWS)) : row_sum[4:0];

    assign at_last_row = (cursor_row == 5'(ROWS - 1));
    assign adv_row     = at_last_row ? cursor_row : cursor_row + 5'd1;
    assign adv_top     = !at_last_row ? top_row :
                         (top_row == 5'(ROWS - 1)) ? 5'd0 : top_row + 5'd1;

    assign bus.char_ready = (state == S_IDLE) && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_CLEAR;
            busy           <= 1'b1;
            fill_row       <= 5'd0;
            fill_col       <= 7'd0;
            cursor_row     <= 5'd0;
            cursor_col     <= 7'd0;
            top_row        <= 5'd0;
            bus.write_en   <= 1'b0;
            bus.write_row  <= 5'd0;
            bus.write_col  <= 7'd0;
            bus.write_char <= BLANK;
        end else begin
            bus.write_en <= 1'b0;
            if (clear) begin
                state      <= S_CLEAR;
                busy       <= 1'b1;
                fill_row   <= 5'd0;
                fill_col   <= 7'd0;
                cursor_row <= 5'd0;
                cursor_col <= 7'd0;
                top_row    <= 5'd0;
            end else begin
                case (state)
                    S_CLEAR: begin
                        bus.write_en   <= 1'b1;
                        bus.write_row  <= fill_row;
                        bus.write_col  <= fill_col;
                        bus.write_char <= BLANK;
                        if (fill_col == 7'(COLS - 1)) begin
                            fill_col <= 7'd0;
                            if (fill_row == 5'(ROWS - 1)) begin
                                fill_row <= 5'd0;
                                state    <= S_IDLE;
                                busy     <= 1'b0;
                            end else begin
                                fill_row <= fill_row + 5'd1;
                            end
                        end else begin
                            fill_col <= fill_col + 7'd1;
                        end
                    end

                    // cursor/top_row already point at the new line here
                    S_LINE_CLR: begin
                        bus.write_en   <= 1'b1;
                        bus.write_row  <= prow;
                        bus.write_col  <= fill_col;
                        bus.write_char <= BLANK;
                        if (fill_col == 7'(COLS - 1)) begin
                            fill_col <= 7'd0;
                            state    <= S_IDLE;
                            busy     <= 1'b0;
                        end else begin
                            fill_col <= fill_col + 7'd1;
                        end
                    end

                    S_IDLE: begin
                        if (bus.char_valid) begin
                            case (bus.char_data)
                                8'h0A: begin
                                    cursor_col <= 7'd0;
                                    cursor_row <= adv_row;
                                    top_row    <= adv_top;
                                    fill_col   <= 7'd0;
                                    state      <= S_LINE_CLR;
                                    busy       <= 1'b1;
                                end
                                8'h0D: cursor_col <= 7'd0;
                                8'h08: begin
                                    if (cursor_col != 7'd0) begin
                                        cursor_col     <= cursor_col - 7'd1;
                                        bus.write_en   <= 1'b1;
                                        bus.write_row  <= prow;
                                        bus.write_col  <= cursor_col - 7'd1;
                                        bus.write_char <= BLANK;
                                    end
                                end
                                8'h0C: begin
                                    state      <= S_CLEAR;
                                    busy       <= 1'b1;
                                    fill_row   <= 5'd0;
                                    fill_col   <= 7'd0;
                                    cursor_row <= 5'd0;
                                    cursor_col <= 7'd0;
                                    top_row    <= 5'd0;
                                end
                                default: begin
                                    bus.write_en   <= 1'b1;
                                    bus.write_row  <= prow;
                                    bus.write_col  <= cursor_col;
                                    bus.write_char <= bus.char_data;
                                    if (cursor_col == 7'(COLS - 1)) begin
                                        cursor_col <= 7'd0;
                                        cursor_row <= adv_row;
                                        top_row    <= adv_top;
                                        fill_col   <= 7'd0;
                                        state      <= S_LINE_CLR;
                                        busy       <= 1'b1;
                                    end else begin
                                        cursor_col <= cursor_col + 7'd1;
                                    end
                                end
                            endcase
                        end
                    end

                    default: begin
                        state <= S_CLEAR;
                        busy  <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_console_writer.sv
// tb/tb_console_writer.sv - scoreboard bench for console_writer
module tb_console_writer;
    localparam int ROWS = 30;
    localparam int COLS = 80;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       clear = 1'b0;
    logic       busy;
    logic [4:0] cursor_row;
    logic [6:0] cursor_col;
    logic [4:0] top_row;

    console_writer_if bus ();

    console_writer #(.ROWS(ROWS), .COLS(COLS), .BLANK(8'h20)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .clear      (clear),
        .busy       (busy),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .top_row    (top_row)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [19:0] exp_q[$];
    int          m_row = 0;
    int          m_col = 0;
    int          m_top = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void push_w(input int r, input int c, input logic [7:0] ch);
        exp_q.push_back({5'(r), 7'(c), ch});
    endfunction

    function automatic void push_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                push_w(r, c, 8'h20);
        m_row = 0;
        m_col = 0;
        m_top = 0;
    endfunction

    function automatic void model_advance();
        if (m_row < ROWS - 1) m_row++;
        else m_top = (m_top + 1) % ROWS;
        for (int c = 0; c < COLS; c++)
            push_w((m_top + m_row) % ROWS, c, 8'h20);
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        int pr;
        pr = (m_top + m_row) % ROWS;
        case (b)
            8'h0A: begin m_col = 0; model_advance(); end
            8'h0D: m_col = 0;
            8'h08: if (m_col > 0) begin m_col--; push_w(pr, m_col, 8'h20); end
            8'h0C: push_clear();
            default: begin
                push_w(pr, m_col, b);
                if (m_col < COLS - 1) m_col++;
                else begin m_col = 0; model_advance(); end
            end
        endcase
    endfunction

    // write port sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (rst_n && bus.write_en) begin
            if (exp_q.size() == 0)
                check("unexpected_write", {bus.write_row, bus.write_col, bus.write_char}, 32'hFFFF_FFFF);
            else
                check("write", {bus.write_row, bus.write_col, bus.write_char}, exp_q.pop_front());
        end
    end

    task automatic wait_ready(output int n);
        n = 0;
        while (!bus.char_ready && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ready_timeout", bus.char_ready, 1);
    endtask

    task automatic send(input logic [7:0] b, output int n);
        wait_ready(n);
        model_byte(b);
        bus.char_valid = 1'b1;
        bus.char_data  = b;
        @(posedge clk);
        #1;
        bus.char_valid = 1'b0;
    endtask

    task automatic check_cursor(input string tag);
        check({tag, "_row"}, cursor_row, m_row);
        check({tag, "_col"}, cursor_col, m_col);
        check({tag, "_top"}, top_row, m_top);
    endtask

    task automatic check_reset_values();
        check("rst_write_en", bus.write_en, 0);
        check("rst_write_row", bus.write_row, 0);
        check("rst_write_col", bus.write_col, 0);
        check("rst_write_char", bus.write_char, 8'h20);
        check("rst_busy", busy, 1);
        check("rst_char_ready", bus.char_ready, 0);
        check("rst_cursor_row", cursor_row, 0);
        check("rst_cursor_col", cursor_col, 0);
        check("rst_top_row", top_row, 0);
    endtask

    initial begin
        int n;
        bus.char_valid = 1'b0;
        bus.char_data  = 8'h00;

        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_values();

        push_clear();
        rst_n = 1'b1;
        wait_ready(n);
        check("init_clear_cycles", n, ROWS * COLS);
        check("init_busy", busy, 0);
        check_cursor("init");

        send(8'h41, n);
        send(8'h42, n);
        check("back_to_back", n, 0);
        check_cursor("ab");
        send(8'h08, n);
        check_cursor("bs");
        send(8'h0D, n);
        send(8'h08, n);
        check_cursor("bs_col0");

        for (int i = 0; i < COLS; i++) send(8'h78, n);
        wait_ready(n);
        check("wrap_lineclr_cycles", n, COLS);
        check_cursor("wrap");

        for (int i = 0; i < 28; i++) send(8'h0A, n);
        wait_ready(n);
        check_cursor("row29");
        send(8'h0A, n);
        wait_ready(n);
        check("scroll_top", top_row, 1);
        check_cursor("scroll1");
        for (int i = 0; i < 29; i++) send(8'h0A, n);
        wait_ready(n);
        check("scroll_wrap_top", top_row, 0);

        send(8'h5A, n);
        for (int i = 0; i < 5; i++) send(8'h0A, n);
        send(8'h61, n);
        send(8'h62, n);
        send(8'h63, n);
        send(8'h5A, n);
        check_cursor("top5");

        send(8'h0A, n);
        repeat (10) begin @(posedge clk); #1; end
        @(negedge clk);
        #1;
        check("lineclr_remaining", exp_q.size(), COLS - 10);
        exp_q.delete();
        push_clear();
        clear = 1'b1;
        bus.char_valid = 1'b1;
        bus.char_data  = 8'h51;
        #1;
        check("clear_blocks_ready", bus.char_ready, 0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        bus.char_valid = 1'b0;
        check("clear_busy", busy, 1);
        check_cursor("clear_mid_line");
        wait_ready(n);
        check("clear_restart_cycles", n, ROWS * COLS);

        send(8'h68, n);
        send(8'h69, n);
        send(8'h0C, n);
        wait_ready(n);
        check("ff_clear_cycles", n, ROWS * COLS);
        check_cursor("ff");

        push_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        repeat (100) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check_reset_values();
        exp_q.delete();
        @(posedge clk);
        #1;
        push_clear();
        rst_n = 1'b1;
        wait_ready(n);
        check("reclear_cycles", n, ROWS * COLS);
        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
